ksw_row_ctrl: RTL

KSW_ROW_CTRL -- requirements
Module: ksw_row_ctrl

---
 rtl/ksw_pkg.sv | 7 +
 rtl/ksw_pipe_delay.sv | 30 +++
 rtl/ksw_row_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ksw_pkg.sv
// ksw_pkg: shared state encoding, byte width and parameter defaults for the KSW row controller.
package ksw_pkg;
    localparam int BW      = 8;
    localparam int TW_DEF  = 10;
    localparam int LAT_DEF = 2;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/ksw_pipe_delay.sv
// ksw_pipe_delay: LAT-deep valid/index delay line that shifts every cycle regardless of stalls.
module ksw_pipe_delay #(
    parameter int LAT = 2,
    parameter int W   = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);
    logic [LAT-1:0] v_q;
    logic [W-1:0]   d_q [LAT];
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < LAT; i++) d_q[i] <= '0;
        end else begin
            v_q[0] <= valid_i;
            d_q[0] <= data_i;
            for (int i = 1; i < LAT; i++) begin
                v_q[i] <= v_q[i-1];
                d_q[i] <= d_q[i-1];
            end
        end
    end
    assign valid_o = v_q[LAT-1];
    assign data_o  = d_q[LAT-1];
endmodule

// File: rtl/ksw_row_ctrl.sv
// ksw_row_ctrl: sweeps columns st..en through the datapath, chaining carry bytes column to column.
// Optional KSW_ROW_CTRL_PERF_EN adds saturating busy-cycle and stall counters.
module ksw_row_ctrl
    import ksw_pkg::*;
#(
    parameter int LAT = LAT_DEF,
    parameter int TW  = TW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [TW-1:0] st,
    input  logic [TW-1:0] en,
    input  logic [BW-1:0] x1_init,
    input  logic [BW-1:0] v1_init,
    input  logic [BW-1:0] x21_init,
    input  logic          mem_ready,
    input  logic [BW-1:0] dp_x1_out,
    input  logic [BW-1:0] dp_v1_out,
    input  logic [BW-1:0] dp_x21_out,
    output logic          dp_valid,
    output logic [TW-1:0] dp_t,
    output logic [BW-1:0] dp_x1_in,
    output logic [BW-1:0] dp_v1_in,
    output logic [BW-1:0] dp_x21_in,
    output logic          wb_valid,
    output logic [TW-1:0] wb_t,
    output logic          busy,
    output logic          done
`ifdef KSW_ROW_CTRL_PERF_EN
    ,
    output logic [31:0]   perf_cycles,
    output logic [31:0]   perf_stalls
`endif
);
    localparam int CW = $clog2(LAT + 1) + 1;

    state_t        state_q, state_d;
    logic [TW-1:0] ptr_q, ptr_d, en_q, en_d;
    logic [BW-1:0] x1_q, x1_d, v1_q, v1_d, x21_q, x21_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          issue;

    assign issue = (state_q == ISSUE) && mem_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        en_d    = en_q;
        x1_d    = x1_q;
        v1_d    = v1_q;
        x21_d   = x21_q;
        cnt_d   = cnt_q + CW'(issue) - CW'(wb_valid);
        case (state_q)
            IDLE: if (start) begin
                if (st <= en) begin
                    state_d = ISSUE;
                    ptr_d   = st;
                    en_d    = en;
                    x1_d    = x1_init;
                    v1_d    = v1_init;
                    x21_d   = x21_init;
                end else begin
                    state_d = DONE;
                end
            end
            ISSUE: if (issue) begin
                x1_d  = dp_x1_out;
                v1_d  = dp_v1_out;
                x21_d = dp_x21_out;
                // Hold the pointer on the last column so en = all-ones cannot wrap.
                if (ptr_q == en_q) state_d = DRAIN;
                else ptr_d = ptr_q + 1'b1;
            end
            // Leave as soon as the final retire empties the pipeline.
            DRAIN: if (cnt_d == '0) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            en_q    <= '0;
            x1_q    <= '0;
            v1_q    <= '0;
            x21_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            en_q    <= en_d;
            x1_q    <= x1_d;
            v1_q    <= v1_d;
            x21_q   <= x21_d;
            cnt_q   <= cnt_d;
        end
    end

    ksw_pipe_delay #(.LAT(LAT), .W(TW)) u_delay (
        .clk     (clk),
        .rst     (rst),
        .valid_i (issue),
        .data_i  (ptr_q),
        .valid_o (wb_valid),
        .data_o  (wb_t)
    );

    assign dp_valid  = issue;
    assign dp_t      = ptr_q;
    assign dp_x1_in  = x1_q;
    assign dp_v1_in  = v1_q;
    assign dp_x21_in = x21_q;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;

`ifdef KSW_ROW_CTRL_PERF_EN
    logic [31:0] cyc_q, stl_q;
    always_ff @(posedge clk) begin
        if (rst || (state_q == IDLE && start)) begin
            cyc_q <= '0;
            stl_q <= '0;
        end else begin
            if (busy && ~&cyc_q) cyc_q <= cyc_q + 32'd1;
            if (state_q == ISSUE && !mem_ready && ~&stl_q) stl_q <= stl_q + 32'd1;
        end
    end
    assign perf_cycles = cyc_q;
    assign perf_stalls = stl_q;
`endif
endmodule
